// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the 8 x 16-bit register file: round-robin between ALU and MEM
// onto the single rf write port, plus a per-register busy scoreboard for RAW stalls.
module rf_wb_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int SEL_WIDTH  = 3,
    parameter int NUM_REGS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [SEL_WIDTH-1:0]  alu_sel,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [SEL_WIDTH-1:0]  mem_sel,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  issue_valid,
    input  logic [SEL_WIDTH-1:0]  issue_dst,
    input  logic [SEL_WIDTH-1:0]  rd_a_sel,
    input  logic [SEL_WIDTH-1:0]  rd_b_sel,
    output logic                  src_stall,
    output logic [NUM_REGS-1:0]   reg_busy,
    output logic                  wr_en,
    output logic                  write_rf_bool,
    output logic [SEL_WIDTH-1:0]  wr_sel,
    output logic [DATA_WIDTH-1:0] wr_port
);

    typedef enum logic {
        RR_ALU = 1'b0,
        RR_MEM = 1'b1
    } rr_t;

    rr_t                rr;
    logic [NUM_REGS-1:0] busy_next;

    // The rr pointer only decides contested cycles; a lone requester always wins.
    always_comb begin
        alu_ready = alu_valid && (!mem_valid || rr == RR_ALU);
        mem_ready = mem_valid && (!alu_valid || rr == RR_MEM);
    end

    // Set is applied after clear so a newly issued writer keeps the register busy.
    always_comb begin
        busy_next = reg_busy;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (wr_en && wr_sel == SEL_WIDTH'(r))
                busy_next[r] = 1'b0;
            if (issue_valid && issue_dst == SEL_WIDTH'(r))
                busy_next[r] = 1'b1;
        end
    end

    assign src_stall = reg_busy[rd_a_sel] | reg_busy[rd_b_sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr            <= RR_MEM;
            wr_en         <= 1'b0;
            write_rf_bool <= 1'b0;
            wr_sel        <= '0;
            wr_port       <= '0;
            reg_busy      <= '0;
        end else begin
            if (alu_valid && mem_valid)
                rr <= (rr == RR_MEM) ? RR_ALU : RR_MEM;
            wr_en         <= alu_ready | mem_ready;
            write_rf_bool <= alu_ready | mem_ready;
            if (alu_ready) begin
                wr_sel  <= alu_sel;
                wr_port <= alu_data;
            end else if (mem_ready) begin
                wr_sel  <= mem_sel;
                wr_port <= mem_data;
            end
            reg_busy <= busy_next;
        end
    end

endmodule
